i2c_master: RTL and testbench
=============================

Name: i2c_master

Overview:
- Single-byte I2C bus master. Generates START, a 7-bit address plus R/W bit, one data byte (write or read), the ACK/NACK bits, and STOP on a 2-wire bus.
- Pairs with the team's i2c slave, which has an 8-entry memory bank. This block is the initiator side used by the host logic.
- Bit timing uses the same 4-phase scheme as the slave: 400 clk per bit at 50 MHz / 125 kHz, with 4 phases of 100 clk each.

Parameters:
- board_freq, 50000000, system clock frequency in Hz
- i2c_freq, 125000, SCL frequency in Hz
- single_bit_dur, board_freq/i2c_freq (400), clk cycles per bit (derived)
- delta, single_bit_dur/4 (100), clk cycles per phase (derived)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- newd  input  1  start request, sampled only in IDLE
- op  input  1  transfer direction: 0 = write, 1 = read (becomes the R/W bit)
- addr  input  7  target slave address
- din  input  8  write data
- dout  output  8  read data, registered
- sda  inout  1  serial data, tri-stated when sda_en=0
- sclk  output  1  serial clock, driven push-pull
- busy  output  1  high from transfer accept until done
- ack_err  output  1  at least one slave NACK seen in the last transfer
- done  output  1  one-clk pulse when STOP completes

Behaviour:
- Interface decisions: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: sclk=1, sda_en=1, sda driven 1, dout=0, busy=0, ack_err=0, done=0, state=IDLE, phase counter=0.
- Reset asserted mid-transfer aborts on the next edge and gives the same values. No done pulse.
- Phase counter: count runs 0..399 only while busy. pulse = count/100 (0..3). count is held at 0 in IDLE.
- States: IDLE, START, WRITE_ADDR, ADDR_ACK, WRITE_DATA, READ_DATA, DATA_ACK, MASTER_NACK, STOP.
- Each non-IDLE state lasts an integral number of 400-clk bit periods. Transitions occur at count==399.
- IDLE: on newd=1, latch {addr,op} into an 8-bit shift register and latch din. Set busy=1, clear ack_err, go to START. newd while busy is ignored.
- START:
  - pulse 0,1: sclk=1, sda=1
  - pulse 2: sclk=1, sda=0 (the START edge)
  - pulse 3: sclk=0, sda=0
- Data bits (WRITE_ADDR, WRITE_DATA, MASTER_NACK):
  - sclk=0 in pulse 0,1; sclk=1 in pulse 2,3.
  - sda is updated only at count==100, MSB first.
  - 8 bits, counted by bit_cnt 0..7. bit_cnt wraps to 0 on exit.
- Receive bits (ADDR_ACK, DATA_ACK, READ_DATA):
  - sda_en=0 for the whole state.
  - sda is sampled at count==200.
  - READ_DATA shifts MSB first into dout; dout updates after the 8th sample.
- ADDR_ACK:
  - A sampled 1 sets ack_err.
  - Next state is WRITE_DATA if op=0, READ_DATA if op=1.
- WRITE_DATA goes to DATA_ACK. DATA_ACK sets ack_err on a sampled 1, then goes to STOP.
- READ_DATA goes to MASTER_NACK. MASTER_NACK drives sda=1 (single-byte read ends with NACK), then goes to STOP.
- STOP:
  - pulse 0: sclk=0, sda=0
  - pulse 1: sclk=1, sda=0
  - pulse 2,3: sclk=1, sda=1 (the STOP edge is at count==200)
  - At count==399: busy=0, done=1 for exactly one clk, go to IDLE.
- Total transfer length: 20 bit periods = 8000 clk from entering START to done. This is the same for write and read.
- SDA transitions occur only while sclk=0, except the START and STOP edges.

Optional Feature:
- Macro: I2C_NACK_ABORT_EN.
- Defined: a NACK in ADDR_ACK sets ack_err and goes directly to STOP, skipping the data byte. Transfer length is 11 bit periods = 4400 clk. dout is unchanged.
- Undefined: the transfer always runs its full 20 bit periods; ack_err is only reported.

Test Plan:
- Write, addr=0x05, din=0xA3, ACKing slave model:
  - sda during sclk-high bits shows 0x0A (0000101_0) then 0xA3.
  - ack_err=0; done pulses 8000 clk after START entry.
- Read, addr=0x03, slave drives 0x03:
  - Address byte is 0x07.
  - dout=0x03 after done; master drives NACK=1 in bit 19; ack_err=0.
- Address NACK (slave releases sda), op=0:
  - ack_err=1.
  - Macro off: done at 8000 clk. Macro on: done at 4400 clk.
- newd pulsed again at 1000 clk into a transfer with a different addr: ignored; only one done; original address on the bus.
- rst at 3000 clk: next cycle sclk=1, sda=1, busy=0, no done. A subsequent newd runs a clean transfer.
- Timing check: every sclk period = 400 clk, high 200 clk. Every non-START/STOP sda change occurs at count==100 while sclk=0.

Source files
------------

// File: rtl/i2c_master.sv
`default_nettype none
// ============================================================================
// Module   : i2c_master
// Purpose  : Single-byte I2C bus master (START, addr+R/W, one data byte,
//            ACK/NACK, STOP) with 4-phase bit timing.
//            Optional macro I2C_NACK_ABORT_EN: address NACK jumps to STOP.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_master #(
    parameter int BOARD_FREQ = 50_000_000,
    parameter int I2C_FREQ   = 125_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       newd,
    input  logic       op,
    input  logic [6:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    inout  wire        sda,
    output logic       sclk,
    output logic       busy,
    output logic       ack_err,
    output logic       done
);
    localparam int c_BIT_DUR = BOARD_FREQ / I2C_FREQ;
    localparam int c_DELTA   = c_BIT_DUR / 4;
    localparam int c_CW      = $clog2(c_BIT_DUR);
    localparam logic [c_CW-1:0] c_P1   = c_CW'(c_DELTA);
    localparam logic [c_CW-1:0] c_P2   = c_CW'(2 * c_DELTA);
    localparam logic [c_CW-1:0] c_P3   = c_CW'(3 * c_DELTA);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_BIT_DUR - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_WRITE_ADDR, S_ADDR_ACK, S_WRITE_DATA,
        S_READ_DATA, S_DATA_ACK, S_MASTER_NACK, S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [c_CW-1:0] count_q, count_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      tx_q, tx_d, wdata_q, wdata_d, dout_q, dout_d;
    logic [6:0]      rx_q, rx_d;
    logic            sclk_q, sclk_d, sda_out_q, sda_out_d, sda_en_q, sda_en_d;
    logic            busy_q, busy_d, ack_err_q, ack_err_d, done_q, done_d;
    logic [1:0]      pulse_d;
    logic            last;
    logic            sda_in;

    assign sda     = sda_en_q ? sda_out_q : 1'bz;
    assign sda_in  = sda;
    assign dout    = dout_q;
    assign sclk    = sclk_q;
    assign busy    = busy_q;
    assign ack_err = ack_err_q;
    assign done    = done_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        wdata_d   = wdata_q;
        dout_d    = dout_q;
        rx_d      = rx_q;
        sclk_d    = sclk_q;
        sda_out_d = sda_out_q;
        sda_en_d  = sda_en_q;
        busy_d    = busy_q;
        ack_err_d = ack_err_q;
        done_d    = 1'b0;
        last      = (count_q == c_LAST);
        count_d   = '0;
        if (busy_q && !last) count_d = count_q + 1'b1;

        case (state_q)
            S_IDLE: if (newd) begin
                tx_d      = {addr, op};
                wdata_d   = din;
                busy_d    = 1'b1;
                ack_err_d = 1'b0;
                state_d   = S_START;
            end
            S_START: if (last) state_d = S_WRITE_ADDR;
            S_WRITE_ADDR, S_WRITE_DATA, S_READ_DATA: begin
                if (state_q == S_READ_DATA && count_q == c_P2) begin
                    rx_d = {rx_q[5:0], sda_in};
                    if (bit_cnt_q == 3'd7) dout_d = {rx_q, sda_in};
                end
                if (last) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        case (state_q)
                            S_WRITE_ADDR: state_d = S_ADDR_ACK;
                            S_WRITE_DATA: state_d = S_DATA_ACK;
                            default:      state_d = S_MASTER_NACK;
                        endcase
                    end
                end
            end
            S_ADDR_ACK: begin
                if (count_q == c_P2 && sda_in) ack_err_d = 1'b1;
`ifdef I2C_NACK_ABORT_EN
                if (last) state_d = ack_err_q ? S_STOP : (tx_q[0] ? S_READ_DATA : S_WRITE_DATA);
`else
                if (last) state_d = tx_q[0] ? S_READ_DATA : S_WRITE_DATA;
`endif
            end
            S_DATA_ACK: begin
                if (count_q == c_P2 && sda_in) ack_err_d = 1'b1;
                if (last) state_d = S_STOP;
            end
            S_MASTER_NACK: if (last) state_d = S_STOP;
            S_STOP: if (last) begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Line levels are computed for the upcoming state/count so they line up with it.
        pulse_d = (count_d >= c_P3) ? 2'd3 : (count_d >= c_P2) ? 2'd2 :
                  (count_d >= c_P1) ? 2'd1 : 2'd0;
        case (state_d)
            S_START: begin
                sclk_d    = (pulse_d != 2'd3);
                sda_out_d = (pulse_d < 2'd2);
                sda_en_d  = 1'b1;
            end
            S_WRITE_ADDR, S_WRITE_DATA: begin
                sclk_d   = pulse_d[1];
                sda_en_d = 1'b1;
                if (count_d == c_P1)
                    sda_out_d = (state_d == S_WRITE_ADDR) ? tx_q[~bit_cnt_d] : wdata_q[~bit_cnt_d];
            end
            S_MASTER_NACK: begin
                sclk_d   = pulse_d[1];
                sda_en_d = 1'b1;
                if (count_d == c_P1) sda_out_d = 1'b1;
            end
            S_ADDR_ACK, S_DATA_ACK, S_READ_DATA: begin
                sclk_d   = pulse_d[1];
                sda_en_d = 1'b0;
            end
            S_STOP: begin
                sclk_d    = (pulse_d != 2'd0);
                sda_out_d = pulse_d[1];
                sda_en_d  = 1'b1;
            end
            default: begin
                sclk_d    = 1'b1;
                sda_out_d = 1'b1;
                sda_en_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= '0;
            wdata_q   <= '0;
            dout_q    <= '0;
            rx_q      <= '0;
            sclk_q    <= 1'b1;
            sda_out_q <= 1'b1;
            sda_en_q  <= 1'b1;
            busy_q    <= 1'b0;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            wdata_q   <= wdata_d;
            dout_q    <= dout_d;
            rx_q      <= rx_d;
            sclk_q    <= sclk_d;
            sda_out_q <= sda_out_d;
            sda_en_q  <= sda_en_d;
            busy_q    <= busy_d;
            ack_err_q <= ack_err_d;
            done_q    <= done_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_i2c_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i2c_master
// Purpose  : Bench for i2c_master: open-drain slave model, bus monitor,
//            directed table plus randomized transfers against a protocol model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_master;
`ifdef I2C_NACK_ABORT_EN
    localparam bit c_ABORT = 1'b1;
`else
    localparam bit c_ABORT = 1'b0;
`endif
    localparam int c_NACK_LEN = c_ABORT ? 4400 : 8000;
    localparam int c_NACK_NB  = c_ABORT ? 10 : 19;

    typedef struct {
        bit       op;
        bit [6:0] addr;
        bit [7:0] din;
        bit       present;
        bit       data_ack;
        bit [7:0] rd;
        bit [7:0] e_abyte;
        bit       e_err;
        bit [7:0] e_data;
        bit       e_last;
        bit [7:0] e_dout;
        int       e_len;
        int       e_nbits;
    } vec_t;

    logic       clk = 1'b0, rst = 1'b1, newd = 1'b0, op = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] din = '0;
    logic [7:0] dout;
    logic       sclk, busy, ack_err, done;
    wire        sda;
    logic       s_low = 1'b0;

    pullup (sda);
    assign sda = s_low ? 1'b0 : 1'bz;

    i2c_master dut (
        .clk(clk), .rst(rst), .newd(newd), .op(op), .addr(addr), .din(din),
        .dout(dout), .sda(sda), .sclk(sclk), .busy(busy), .ack_err(ack_err), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0, failures = 0;
    int   nbits = 0, nstarts = 0, nstops = 0, ndone = 0, tviol = 0;
    int   last_rise = 0, prev_rise = 0, t0 = 0;
    bit   lr_v = 0, pr_v = 0, mon_en = 0;
    logic bits [0:31];
    logic p_sclk = 1'b1, p_sda = 1'b1;
    bit   s_present = 0, s_data_ack = 0;
    bit [7:0] s_rd = '0, model_dout = '0;
    vec_t vt [3];

    // Bus monitor: START/STOP events, bit capture at SCL rise, timing rules.
    always @(negedge clk) begin
        logic b;
        b = (sda === 1'b0) ? 1'b0 : 1'b1;
        if (done) ndone++;
        if (mon_en) begin
            if (b != p_sda && sclk && p_sclk) begin
                if (!b) begin nstarts++; nbits = 0; end
                else nstops++;
                lr_v = 0; pr_v = 0;
            end else if (b != p_sda && sclk && !p_sclk) tviol++;
            else if (b != p_sda && !sclk && lr_v && (cyc - last_rise) != 200 && (cyc - last_rise) != 300)
                tviol++;
            if (sclk && !p_sclk) begin
                if (nbits < 32) bits[nbits] = b;
                nbits++;
                prev_rise = last_rise; pr_v = lr_v;
                last_rise = cyc; lr_v = 1;
            end
            if (!sclk && p_sclk && lr_v) begin
                if (cyc - last_rise != 200) tviol++;
                if (pr_v && last_rise - prev_rise != 400) tviol++;
            end
        end
        p_sclk = sclk; p_sda = b;
    end

    // Open-drain slave: bit k of the frame is set up on the SCL fall before it.
    always @(negedge sclk) begin
        int k;
        k = nbits;
        s_low = 1'b0;
        if (s_present && nstarts > 0) begin
            if (k == 8) s_low = 1'b1;
            else if (k >= 9 && k <= 16 && bits[7] === 1'b1) s_low = !s_rd[16-k];
            else if (k == 17 && bits[7] === 1'b0 && s_data_ack) s_low = 1'b1;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic vec_t model(input bit o, input bit [6:0] a, input bit [7:0] d,
                                   input bit pres, input bit dack, input bit [7:0] rd,
                                   input bit [7:0] prev);
        vec_t v;
        bit   aborted;
        aborted   = c_ABORT && !pres;
        v.op = o; v.addr = a; v.din = d; v.present = pres; v.data_ack = dack; v.rd = rd;
        v.e_abyte = {a, o};
        v.e_err   = !pres || (!o && !dack);
        v.e_data  = o ? (pres ? rd : 8'hFF) : d;
        v.e_last  = o ? 1'b1 : !(pres && dack);
        v.e_dout  = (o && !aborted) ? v.e_data : prev;
        v.e_len   = (aborted ? 11 : 20) * 400;
        v.e_nbits = aborted ? 10 : 19;
        return v;
    endfunction

    task automatic apply_vec(input vec_t v, input string tag, input int inject);
        int       lat;
        bit       got;
        bit [7:0] ab, db;
        lat = 0; got = 0;
        s_present = v.present; s_data_ack = v.data_ack; s_rd = v.rd;
        nstarts = 0; nstops = 0; ndone = 0; tviol = 0; nbits = 0;
        @(negedge clk);
        op = v.op; addr = v.addr; din = v.din; newd = 1'b1;
        @(posedge clk); #1;
        newd = 1'b0; t0 = cyc;
        for (int i = 1; i <= 9000 && !got; i++) begin
            @(negedge clk);
            if (i == inject) begin addr = ~v.addr; newd = 1'b1; end
            else newd = 1'b0;
            if (done) begin got = 1; lat = cyc - t0; end
        end
        newd = 1'b0;
        repeat (20) @(negedge clk);
        ab = '0; db = '0;
        for (int j = 0; j < 8; j++) begin
            ab = {ab[6:0], bits[j]};
            db = {db[6:0], bits[9+j]};
        end
        chk({tag, "_done_seen"}, int'(got), 1);
        chk({tag, "_latency"}, lat, v.e_len);
        chk({tag, "_done_count"}, ndone, 1);
        chk({tag, "_busy_idle"}, int'(busy), 0);
        chk({tag, "_starts"}, nstarts, 1);
        chk({tag, "_stops"}, nstops, 1);
        chk({tag, "_timing"}, tviol, 0);
        chk({tag, "_scl_rises"}, nbits, v.e_nbits);
        chk({tag, "_addr_byte"}, int'(ab), int'(v.e_abyte));
        chk({tag, "_addr_ack_bit"}, int'(bits[8]), int'(!v.present));
        chk({tag, "_ack_err"}, int'(ack_err), int'(v.e_err));
        chk({tag, "_dout"}, int'(dout), int'(v.e_dout));
        if (v.e_nbits == 19) begin
            chk({tag, "_data_byte"}, int'(db), int'(v.e_data));
            chk({tag, "_bit19"}, int'(bits[17]), int'(v.e_last));
        end
        model_dout = v.e_dout;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vt[0] = '{op:1'b0, addr:7'h05, din:8'hA3, present:1'b1, data_ack:1'b1, rd:8'h00,
                  e_abyte:8'h0A, e_err:1'b0, e_data:8'hA3, e_last:1'b0, e_dout:8'h00,
                  e_len:8000, e_nbits:19};
        vt[1] = '{op:1'b1, addr:7'h03, din:8'h00, present:1'b1, data_ack:1'b0, rd:8'h03,
                  e_abyte:8'h07, e_err:1'b0, e_data:8'h03, e_last:1'b1, e_dout:8'h03,
                  e_len:8000, e_nbits:19};
        vt[2] = '{op:1'b0, addr:7'h50, din:8'h3C, present:1'b0, data_ack:1'b0, rd:8'h00,
                  e_abyte:8'hA0, e_err:1'b1, e_data:8'h3C, e_last:1'b1, e_dout:8'h03,
                  e_len:c_NACK_LEN, e_nbits:c_NACK_NB};

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset_sclk", int'(sclk), 1);
        chk("reset_sda", int'(sda !== 1'b0), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_ack_err", int'(ack_err), 0);
        chk("reset_dout", int'(dout), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        mon_en = 1;

        for (int r = 0; r < 3; r++) apply_vec(vt[r], $sformatf("table%0d", r), 0);

        v = model(1'b0, 7'h22, 8'h5A, 1'b1, 1'b1, 8'h00, model_dout);
        apply_vec(v, "newd_ignored", 1000);

        for (int r = 0; r < 3; r++) begin
            v = model(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom),
                      ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                      8'($urandom), model_dout);
            apply_vec(v, $sformatf("rand%0d", r), 0);
        end

        s_present = 1; s_data_ack = 1; ndone = 0;
        @(negedge clk);
        op = 1'b0; addr = 7'h11; din = 8'h99; newd = 1'b1;
        @(posedge clk); #1;
        newd = 1'b0;
        repeat (3000) @(negedge clk);
        mon_en = 0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_sclk", int'(sclk), 1);
        chk("midrst_sda", int'(sda !== 1'b0), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrst_no_done", ndone, 0);
        model_dout = '0;
        mon_en = 1;
        v = model(1'b1, 7'h3C, 8'h00, 1'b1, 1'b0, 8'hC5, model_dout);
        apply_vec(v, "after_rst", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
